// File: rtl/frame_handshake_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : frame_handshake_receiver                                   |
// | Description : Four-phase handshake frame receiver. Reassembles a frame   |
// |               from CHUNK-bit link words. The first word is a header and  |
// |               is discarded. Each word carries a last flag and odd parity.|
// |               The frame is handed on through valid/ready.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module frame_handshake_receiver #(
   parameter int FRAME_BITS     = 1500,
   parameter int CHUNK          = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int LEN_W          = $clog2(FRAME_BITS + 1)
) (
   input  logic                  clk_receiver,
   input  logic                  rst,
   input  logic                  wire_req,
   input  logic [CHUNK+1:0]      wire_data_deliver,
   output logic                  reg_ack,
   output logic [FRAME_BITS-1:0] frame_data,
   output logic [LEN_W-1:0]      frame_len,
   output logic                  frame_valid,
   input  logic                  frame_ready,
   output logic                  overflow,
   output logic                  parity_err,
   output logic                  timeout_err
);

   localparam int c_TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int c_SLOTS  = FRAME_BITS / CHUNK;
   localparam logic [LEN_W:0]      c_FRAME_BITS = (LEN_W+1)'(FRAME_BITS);
   localparam logic [LEN_W:0]      c_CHUNK_W    = (LEN_W+1)'(CHUNK);
   localparam logic [LEN_W-1:0]    c_CHUNK      = LEN_W'(CHUNK);
   localparam logic [c_TCNT_W-1:0] c_TMO_LAST   =
      (TIMEOUT_CYCLES > 0) ? c_TCNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      S_HDR      = 3'd0,
      S_HDR_ACK  = 3'd1,
      S_DATA     = 3'd2,
      S_DATA_ACK = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0]  r_sync;
   logic [LEN_W-1:0]        r_ptr, w_ptr_nxt;
   logic                    r_last, w_last_nxt;
   logic                    r_stored, w_stored_nxt;
   logic                    r_perr_seen, w_perr_seen_nxt;
   logic [c_TCNT_W-1:0]     r_tcnt;

   logic                    w_ack_nxt, w_valid_nxt, w_ovf_nxt, w_perr_nxt, w_tmo_err_nxt;
   logic [FRAME_BITS-1:0]   w_data_nxt;
   logic [LEN_W-1:0]        w_len_nxt;

   logic                    w_req_s, w_par_ok, w_fits, w_timed, w_tmo;
   logic [CHUNK-1:0]        w_chunk;
   logic [LEN_W-1:0]        w_ptr_adv;

   assign w_req_s   = r_sync[SYNC_STAGES-1];
   assign w_par_ok  = ^wire_data_deliver;
   assign w_chunk   = wire_data_deliver[CHUNK-1:0];
   // Pointer is always a multiple of CHUNK, so this also rejects a partial tail slot.
   assign w_fits    = ({1'b0, r_ptr} + c_CHUNK_W) <= c_FRAME_BITS;
   assign w_ptr_adv = r_stored ? (r_ptr + c_CHUNK) : r_ptr;
   assign w_timed   = (r_state == S_HDR_ACK) || (r_state == S_DATA) || (r_state == S_DATA_ACK);
   assign w_tmo     = (TIMEOUT_CYCLES > 0) && w_timed && (r_tcnt == c_TMO_LAST);

   // Request synchroniser: wire_req is asynchronous to clk_receiver.
   always_ff @(posedge clk_receiver) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], wire_req};
   end

   // Cycle counter for the mid-frame watchdog, restarted on every state change.
   always_ff @(posedge clk_receiver) begin
      if (rst || !w_timed || (w_state_nxt != r_state)) r_tcnt <= '0;
      else                                              r_tcnt <= r_tcnt + 1'b1;
   end

   // Next-state and next-output logic for the handshake FSM.
   always_comb begin
      w_state_nxt     = r_state;
      w_ack_nxt       = reg_ack;
      w_data_nxt      = frame_data;
      w_len_nxt       = frame_len;
      w_valid_nxt     = frame_valid;
      w_ovf_nxt       = overflow;
      w_ptr_nxt       = r_ptr;
      w_last_nxt      = r_last;
      w_stored_nxt    = r_stored;
      w_perr_nxt      = 1'b0;
      w_tmo_err_nxt   = 1'b0;
      // Remembers a parity pulse already issued in the current request phase.
      w_perr_seen_nxt = r_perr_seen & w_req_s;

      case (r_state)
         S_HDR: begin
            if (w_req_s) begin
               if (w_par_ok) begin
                  w_ack_nxt   = 1'b1;
                  w_ptr_nxt   = '0;
                  w_data_nxt  = '0;
                  w_ovf_nxt   = 1'b0;
                  w_state_nxt = S_HDR_ACK;
               end else begin
                  w_perr_nxt      = ~r_perr_seen;
                  w_perr_seen_nxt = 1'b1;
               end
            end
         end
         S_HDR_ACK: begin
            if (!w_req_s) begin
               w_ack_nxt   = 1'b0;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_req_s) begin
               if (w_par_ok) begin
                  if (w_fits) begin
                     for (int k = 0; k < c_SLOTS; k++) begin
                        if (r_ptr == LEN_W'(k * CHUNK))
                           w_data_nxt[k*CHUNK +: CHUNK] = w_chunk;
                     end
                     w_stored_nxt = 1'b1;
                  end else begin
                     w_stored_nxt = 1'b0;
                     w_ovf_nxt    = 1'b1;
                  end
                  w_last_nxt  = wire_data_deliver[CHUNK];
                  w_ack_nxt   = 1'b1;
                  w_state_nxt = S_DATA_ACK;
               end else begin
                  w_perr_nxt      = ~r_perr_seen;
                  w_perr_seen_nxt = 1'b1;
               end
            end
         end
         S_DATA_ACK: begin
            if (!w_req_s) begin
               w_ack_nxt = 1'b0;
               w_ptr_nxt = w_ptr_adv;
               if (r_last) begin
                  w_len_nxt   = w_ptr_adv;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_DATA;
               end
            end
         end
         S_DONE: begin
            if (frame_valid && frame_ready) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = S_HDR;
            end
         end
         default: w_state_nxt = S_HDR;
      endcase

      // Watchdog abort overrides whatever the handshake was about to do.
      if (w_tmo) begin
         w_tmo_err_nxt = 1'b1;
         w_ack_nxt     = 1'b0;
         w_valid_nxt   = 1'b0;
         w_ptr_nxt     = '0;
         w_state_nxt   = S_HDR;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_receiver) begin
      if (rst) begin
         r_state     <= S_HDR;
         r_ptr       <= '0;
         r_last      <= 1'b0;
         r_stored    <= 1'b0;
         r_perr_seen <= 1'b0;
         reg_ack     <= 1'b0;
         frame_data  <= '0;
         frame_len   <= '0;
         frame_valid <= 1'b0;
         overflow    <= 1'b0;
         parity_err  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_last      <= w_last_nxt;
         r_stored    <= w_stored_nxt;
         r_perr_seen <= w_perr_seen_nxt;
         reg_ack     <= w_ack_nxt;
         frame_data  <= w_data_nxt;
         frame_len   <= w_len_nxt;
         frame_valid <= w_valid_nxt;
         overflow    <= w_ovf_nxt;
         parity_err  <= w_perr_nxt;
         timeout_err <= w_tmo_err_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_frame_handshake_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_frame_handshake_receiver                                |
// | Description : Self-checking bench for frame_handshake_receiver with a    |
// |               four-phase sender model and a frame scoreboard.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_frame_handshake_receiver;

   localparam int FRAME_BITS = 12;
   localparam int CHUNK      = 4;
   localparam int LEN_W      = 4;

   typedef struct packed {
      logic [FRAME_BITS-1:0] data;
      logic [LEN_W-1:0]      len;
      logic                  ovf;
   } frame_t;

   logic                  clk_receiver = 1'b0;
   logic                  rst = 1'b1;
   logic                  wire_req = 1'b0;
   logic [CHUNK+1:0]      wire_data_deliver = '0;
   logic                  reg_ack;
   logic [FRAME_BITS-1:0] frame_data;
   logic [LEN_W-1:0]      frame_len;
   logic                  frame_valid;
   logic                  frame_ready = 1'b1;
   logic                  overflow;
   logic                  parity_err;
   logic                  timeout_err;

   int n_tests = 0;
   int n_fail  = 0;
   int perr_cnt = 0;
   int tmo_cnt  = 0;
   int obs_rd   = 0;
   frame_t exp_q[$];
   frame_t obs_q[$];

   frame_handshake_receiver #(
      .FRAME_BITS     (FRAME_BITS),
      .CHUNK          (CHUNK),
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk_receiver      (clk_receiver),
      .rst               (rst),
      .wire_req          (wire_req),
      .wire_data_deliver (wire_data_deliver),
      .reg_ack           (reg_ack),
      .frame_data        (frame_data),
      .frame_len         (frame_len),
      .frame_valid       (frame_valid),
      .frame_ready       (frame_ready),
      .overflow          (overflow),
      .parity_err        (parity_err),
      .timeout_err       (timeout_err)
   );

   always #5 clk_receiver = ~clk_receiver;

   // Record pulses and every frame the consumer accepts.
   always @(negedge clk_receiver) begin
      if (parity_err)  perr_cnt <= perr_cnt + 1;
      if (timeout_err) tmo_cnt  <= tmo_cnt + 1;
      if (frame_valid && frame_ready) obs_q.push_back('{frame_data, frame_len, overflow});
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [CHUNK+1:0] mk(input logic last, input logic [CHUNK-1:0] d);
      mk = {~(^{last, d}), last, d};
   endfunction

   task automatic tick();
      @(posedge clk_receiver);
      #1;
   endtask

   // Four-phase sender: raise req, wait ack, drop req, wait ack release.
   task automatic send_word(input logic [CHUNK+1:0] w, input logic exp_valid);
      int n;
      wire_data_deliver = w;
      wire_req = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!reg_ack && n < 40);
      check("ack_rise_latency", n, 3);
      wire_req = 1'b0;
      n = 0;
      do begin tick(); n++; end while (reg_ack && n < 40);
      check("ack_fall_latency", n, 3);
      check("valid_at_ack_fall", frame_valid, exp_valid);
   endtask

   // Compare the frames observed since the last call against the expected queue.
   task automatic expect_frames(input int cnt);
      frame_t e, o;
      repeat (2) tick();
      check("frame_count", obs_q.size() - obs_rd, cnt);
      while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q[obs_rd];
         obs_rd++;
         check("frame_data", o.data, e.data);
         check("frame_len", o.len, e.len);
         check("overflow", o.ovf, e.ovf);
      end
   endtask

   initial begin
      int n, base;
      logic [CHUNK+1:0] hdr;
      hdr = 6'b100000;

      // Reset state
      repeat (3) tick();
      check("rst_ack", reg_ack, 0);
      check("rst_valid", frame_valid, 0);
      check("rst_data", frame_data, 0);
      check("rst_len", frame_len, 0);
      check("rst_ovf", overflow, 0);
      check("rst_perr", parity_err, 0);
      check("rst_tmo", timeout_err, 0);
      rst = 1'b0;
      tick();

      // Normal frame
      exp_q.push_back('{12'h3A5, 4'd12, 1'b0});
      send_word(hdr, 0);
      send_word(6'b100101, 0);
      send_word(6'b101010, 0);
      send_word(6'b010011, 1);
      expect_frames(1);

      // Parity error then correction within the same request phase
      exp_q.push_back('{12'h095, 4'd8, 1'b0});
      send_word(hdr, 0);
      base = perr_cnt;
      wire_data_deliver = 6'b000101;
      wire_req = 1'b1;
      repeat (8) tick();
      check("perr_no_ack", reg_ack, 0);
      check("perr_one_pulse", perr_cnt - base, 1);
      wire_data_deliver = 6'b100101;
      n = 0;
      do begin tick(); n++; end while (!reg_ack && n < 20);
      check("perr_recover_ack", reg_ack, 1);
      wire_req = 1'b0;
      n = 0;
      do begin tick(); n++; end while (reg_ack && n < 20);
      check("perr_recover_release", reg_ack, 0);
      send_word(mk(1, 4'h9), 1);
      check("perr_still_one", perr_cnt - base, 1);
      expect_frames(1);

      // Early last
      exp_q.push_back('{12'h001, 4'd4, 1'b0});
      send_word(hdr, 0);
      send_word(6'b110001, 1);
      expect_frames(1);

      // Overflow: fourth chunk does not fit
      exp_q.push_back('{12'h321, 4'd12, 1'b1});
      send_word(hdr, 0);
      send_word(mk(0, 4'h1), 0);
      send_word(mk(0, 4'h2), 0);
      send_word(mk(0, 4'h3), 0);
      send_word(mk(1, 4'h4), 1);
      expect_frames(1);

      // Backpressure
      frame_ready = 1'b0;
      exp_q.push_back('{12'h0B7, 4'd8, 1'b0});
      send_word(hdr, 0);
      send_word(mk(0, 4'h7), 0);
      send_word(mk(1, 4'hB), 1);
      wire_data_deliver = hdr;
      wire_req = 1'b1;
      repeat (10) tick();
      check("bp_no_ack", reg_ack, 0);
      check("bp_valid_held", frame_valid, 1);
      check("bp_data_stable", frame_data, 12'h0B7);
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      check("bp_valid_fall", frame_valid, 0);
      n = 0;
      while (!reg_ack && n < 20) begin tick(); n++; end
      check("bp_hdr_acked", reg_ack, 1);
      wire_req = 1'b0;
      n = 0;
      do begin tick(); n++; end while (reg_ack && n < 20);
      frame_ready = 1'b1;
      expect_frames(1);
      exp_q.push_back('{12'h00E, 4'd4, 1'b0});
      send_word(mk(1, 4'hE), 1);
      expect_frames(1);

      // Timeout after the header handshake
      base = tmo_cnt;
      send_word(hdr, 0);
      n = 0;
      do begin tick(); n++; end while (!timeout_err && n < 200);
      check("tmo_cycles", n, 64);
      check("tmo_ack_low", reg_ack, 0);
      tick();
      check("tmo_one_pulse", tmo_cnt - base, 1);
      expect_frames(0);
      exp_q.push_back('{12'h00C, 4'd4, 1'b0});
      send_word(hdr, 0);
      send_word(mk(1, 4'hC), 1);
      expect_frames(1);

      // Reset mid-frame, while an ack is outstanding
      send_word(hdr, 0);
      wire_data_deliver = mk(0, 4'h6);
      wire_req = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!reg_ack && n < 20);
      check("mid_ack_up", reg_ack, 1);
      rst = 1'b1;
      tick();
      check("mid_rst_ack", reg_ack, 0);
      check("mid_rst_data", frame_data, 0);
      check("mid_rst_len", frame_len, 0);
      check("mid_rst_valid", frame_valid, 0);
      check("mid_rst_ovf", overflow, 0);
      rst = 1'b0;
      wire_req = 1'b0;
      repeat (4) tick();
      exp_q.push_back('{12'h00D, 4'd4, 1'b0});
      send_word(hdr, 0);
      send_word(mk(1, 4'hD), 1);
      expect_frames(1);

      check("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
